// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload bundle between pipeline stages.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer, registered ready and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_stage_skid #(
  parameter int DATA_W       = 32,
  parameter int CTRL_W       = 3,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic [1:0]  occ
);

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t in_ent;
  logic ready_q;
  logic up_fire;
  logic dn_fire;

  assign up_fire = up.valid & ready_q;
  assign dn_fire = main_q.v & dn.ready;

  always_comb begin
    in_ent      = '0;
    in_ent.v    = 1'b1;
    in_ent.data = up.data;
    in_ent.ctrl = up.ctrl;
  end

  // Conditions are mutually exclusive; dn_fire implies main is full.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (1'b1)
      flush: begin
        main_d.v    = 1'b0;
        main_d.ctrl = '0;
        skid_d.v    = 1'b0;
        skid_d.ctrl = '0;
        if (CLR_ON_FLUSH) begin
          main_d.data = '0;
          skid_d.data = '0;
        end
      end
      (!flush && !main_q.v): begin
        if (up_fire) main_d = in_ent;
      end
      (!flush && dn_fire): begin
        if (skid_q.v) begin
          main_d = skid_q;
          if (up_fire) begin
            skid_d = in_ent;
          end else begin
            skid_d.v    = 1'b0;
            skid_d.ctrl = '0;
          end
        end else if (up_fire) begin
          main_d = in_ent;
        end else begin
          main_d.v    = 1'b0;
          main_d.ctrl = '0;
        end
      end
      default: begin
        if (up_fire) skid_d = in_ent;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ~skid_d.v;
    end
  end

  assign up.ready = ready_q;
  assign dn.valid = main_q.v;
  assign dn.data  = main_q.data;
  assign dn.ctrl  = main_q.v ? main_q.ctrl : '0;
  assign occ      = {1'b0, main_q.v} + {1'b0, skid_q.v};

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_q.v && !dn.ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid (DATA_W=64, CTRL_W=5).
// Define PIPE_STAGE_PERF_EN to also exercise the performance counters.
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int CW = 5;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic [1:0] occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_skid #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CLR_ON_FLUSH(1'b1)
  ) dut (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .flush(flush),
    .up(up_if),
    .dn(dn_if),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .occ(occ)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
  endtask

  initial begin
    #1_000_000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired before end of test");
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end
  end

  logic [DW+CW-1:0] sb[$];
  logic [DW+CW-1:0] exp_e;
  logic             uf, df;

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    dn_if.ready  = 1'b0;
    drive(1'b0, '0, '0);
    step();
    step();
    chk("rst_ready", up_if.ready, 1'b0);
    chk("rst_valid", dn_if.valid, 1'b0);
    chk("rst_occ", occ, 2'd0);
    chk("rst_ctrl", dn_if.ctrl, 5'd0);
    reset_n = 1'b1;
    step();
    chk("rel_ready", up_if.ready, 1'b1);

    dn_if.ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 64'(i), 5'(i));
      step();
      chk("stream_valid", dn_if.valid, 1'b1);
      chk("stream_data", dn_if.data, 64'(i));
      chk("stream_ctrl", dn_if.ctrl, 5'(i));
      chk("stream_occ", occ, 2'd1);
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_end_valid", dn_if.valid, 1'b0);
    chk("stream_end_ctrl", dn_if.ctrl, 5'd0);
    chk("stream_end_occ", occ, 2'd0);

    dn_if.ready = 1'b0;
    drive(1'b1, 64'hA, 5'h1);
    step();
    chk("bp_a_occ", occ, 2'd1);
    chk("bp_a_ready", up_if.ready, 1'b1);
    drive(1'b1, 64'hB, 5'h2);
    step();
    chk("bp_b_occ", occ, 2'd2);
    chk("bp_b_ready", up_if.ready, 1'b0);
    chk("bp_b_head", dn_if.data, 64'hA);
    drive(1'b1, 64'hC, 5'h3);
    step();
    step();
    chk("bp_c_occ", occ, 2'd2);
    chk("bp_c_head", dn_if.data, 64'hA);
    chk("bp_c_ctrl", dn_if.ctrl, 5'h1);
    dn_if.ready = 1'b1;
    step();
    chk("bp_out_b", dn_if.data, 64'hB);
    chk("bp_out_b_occ", occ, 2'd1);
    chk("bp_out_b_ready", up_if.ready, 1'b1);
    step();
    chk("bp_out_c", dn_if.data, 64'hC);
    chk("bp_out_c_ctrl", dn_if.ctrl, 5'h3);
    drive(1'b0, '0, '0);
    step();
    chk("bp_drain_occ", occ, 2'd0);

    dn_if.ready = 1'b0;
    drive(1'b1, 64'hA1, 5'h15);
    step();
    drive(1'b1, 64'hB2, 5'h0A);
    step();
    chk("fl_pre_occ", occ, 2'd2);
    drive(1'b1, 64'hD4, 5'h1F);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_occ", occ, 2'd0);
    chk("fl_valid", dn_if.valid, 1'b0);
    chk("fl_ctrl", dn_if.ctrl, 5'd0);
    chk("fl_data", dn_if.data, 64'd0);
    chk("fl_ready", up_if.ready, 1'b1);
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    step();
    chk("fl_no_d", dn_if.valid, 1'b0);

    dn_if.ready = 1'b0;
    drive(1'b1, 64'h11, 5'h1);
    step();
    drive(1'b1, 64'h22, 5'h2);
    step();
    drive(1'b0, '0, '0);
    chk("ar_pre_occ", occ, 2'd2);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", dn_if.valid, 1'b0);
    chk("ar_ctrl", dn_if.ctrl, 5'd0);
    chk("ar_occ", occ, 2'd0);
    chk("ar_ready", up_if.ready, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_rel_ready", up_if.ready, 1'b1);
    chk("ar_rel_occ", occ, 2'd0);

    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 99) < 60, {$urandom(), $urandom()},
            5'($urandom()));
      dn_if.ready = $urandom_range(0, 99) < 55;
      if (!dn_if.valid) chk("rnd_gate", dn_if.ctrl, 5'd0);
      uf = up_if.valid & up_if.ready;
      df = dn_if.valid & dn_if.ready;
      if (df) begin
        if (sb.size() == 0) begin
          chk("rnd_underflow", sb.size(), 1);
        end else begin
          exp_e = sb.pop_front();
          chk("rnd_beat", {dn_if.data, dn_if.ctrl}, exp_e);
        end
      end
      if (uf) sb.push_back({up_if.data, up_if.ctrl});
      step();
    end
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (dn_if.valid) begin
        if (sb.size() == 0) begin
          chk("drain_underflow", sb.size(), 1);
        end else begin
          exp_e = sb.pop_front();
          chk("drain_beat", {dn_if.data, dn_if.ctrl}, exp_e);
        end
      end
      step();
    end
    chk("sb_empty", sb.size(), 0);
    chk("drain_occ", occ, 2'd0);

`ifdef PIPE_STAGE_PERF_EN
    reset_n = 1'b0;
    step();
    chk("perf_rst_stall", stall_cnt, 32'd0);
    chk("perf_rst_flush", flush_cnt, 32'd0);
    reset_n = 1'b1;
    step();
    dn_if.ready = 1'b0;
    drive(1'b1, 64'h77, 5'h7);
    step();
    drive(1'b0, '0, '0);
    for (int n = 0; n < 7; n++) step();
    dn_if.ready = 1'b1;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    step();
    chk("perf_stall", stall_cnt, 32'd7);
    chk("perf_flush", flush_cnt, 32'd2);
`endif

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
